seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, clocked successor to the team's combinational 16-bit ALU. It adds a start/busy/done handshake, registered result and flags, carry and overflow flags, and two iterative multi-cycle ops (shift-left and multiply). It sits between the register file and writeback in the datapath labs and is driven by a controller FSM, one operation at a time.

## Interface
- WIDTH, 16, operand/result width (≥4, power of two)
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- start  input  1  request; accepted only when busy=0
- a, b  input  WIDTH  operands, sampled at acceptance
- cin  input  1  carry/borrow in, sampled at acceptance
- opc  input  3  opcode, sampled at acceptance
- w  output  WIDTH  result register
- z  output  1  zero flag: w == 0
- n  output  1  negative flag: w[WIDTH-1]
- c  output  1  carry flag, meaning per opcode
- v  output  1  signed overflow flag
- busy  output  1  high while a multi-cycle op iterates
- done  output  1  one-cycle pulse; w and flags valid from this cycle

## Operation
- Opcodes:
  - 0 ADD: w=a+b+cin; c=carry out; v=signed overflow.
  - 1 SUB: w=a-b-cin; c=borrow out; v=signed overflow.
  - 2 AND, 3 OR, 4 XOR: bitwise.
  - 5 NOT: w=~a.
  - 6 SHL: w=a<<b[SHW-1:0]; c=last bit shifted out, 0 if amount=0.
  - 7 MUL: unsigned, w=low WIDTH bits of a*b; c=1 if any high bit is nonzero.
- v=0 for all opcodes except ADD/SUB.
- z and n are always computed from the new w.
- FSM states:
  - IDLE, busy=0. Start with opc 0–5, or SHL with amount 0: compute, load w and flags next edge, pulse done, stay IDLE.
  - IDLE, start with SHL amount≥1 or MUL: latch operands, load counter (amount, or WIDTH for MUL), clear accumulator, go to BUSY.
  - BUSY, busy=1: one iteration per cycle. SHL shifts 1 bit. MUL does shift-add of one multiplier bit, LSB first.
  - BUSY, counter reaches 0: load w/flags, pulse done, go to IDLE.
- Start while busy=1 is ignored. No queueing, no error.
- Start is accepted in the same cycle that done is high (back-to-back).
- w and flags hold their value between done pulses. Intermediate values never appear on w.
- Arithmetic: ADD/SUB use a WIDTH+1-bit sum. MUL uses a 2·WIDTH-bit product accumulator.

## Timing
- Reset values: w=0, z=0, n=0, c=0, v=0, busy=0, done=0, state=IDLE, counter=0.
- Reset mid-operation aborts: no done is issued and the result is discarded.
- Latency, counted from the accepting edge to done high:
  - opc 0–5: 1 cycle.
  - SHL: amount+1 cycles.
  - MUL: WIDTH+1 cycles.
- busy rises the cycle after acceptance and falls in the cycle done is high.
- Operand inputs may change freely after the accepting edge.
- done is never high on two consecutive cycles from a single start.

## Structure
- alu_pkg:
  - opcode enum (OP_ADD…OP_MUL);
  - state enum (S_IDLE, S_BUSY);
  - function computing c/v for ADD/SUB.
- Sub-module alu_iter_unit: shift/multiply datapath (counter, accumulator, 1-bit shift, shift-add step) with load/step/last signals.
- The top holds the FSM, the single-cycle combinational ops and the result/flag registers.

## Test plan
All scenarios use WIDTH=16.
- ADD a=0x7FFF, b=0x0001, cin=0 → done 1 cycle later; w=0x8000, n=1, v=1, c=0, z=0.
- SUB a=0x0005, b=0x0005, cin=0 → w=0x0000, z=1, c=0. Then SUB a=0x0000, b=0x0001 → w=0xFFFF, c=1, n=1, v=0.
- MUL a=0x0100, b=0x0100 → busy for 16 cycles, done on cycle 17; w=0x0000, z=1, c=1. Then MUL 0x00FF×0x0003 → w=0x02FD, c=0.
- SHL a=0x0001, b=15 → done after 16 cycles, w=0x8000, c=0. Start pulses issued mid-busy change nothing. SHL a=0xFFFF, b=0 → 1-cycle latency, w=0xFFFF, c=0.
- Assert rst_n=0 at cycle 5 of a MUL → all outputs 0, no done. A following ADD 2+3 gives w=5 with 1-cycle latency.
- Start an AND in the done cycle of a MUL → accepted; AND's done comes 1 cycle later; the MUL result is visible during its own done cycle.
- Random sweep over all opcodes: compare against a golden model; check z/n on every done.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the ADD/SUB
// carry/overflow helper.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_MUL = 3'd7
  } opcode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic c;
    logic v;
  } cv_t;

  // carry is bit WIDTH of the (WIDTH+1)-bit sum/difference (borrow for SUB)
  function automatic cv_t addsub_cv(input logic sub, input logic a_msb,
                                    input logic b_msb, input logic r_msb,
                                    input logic carry);
    cv_t f;
    f.c = carry;
    if (sub) f.v = (a_msb ^ b_msb) & (r_msb ^ a_msb);
    else     f.v = ~(a_msb ^ b_msb) & (r_msb ^ a_msb);
    return f;
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Start/busy/done request bus between the controller FSM and seq_alu.
interface seq_alu_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [2:0]       opc;
  logic [WIDTH-1:0] w;
  logic             z;
  logic             n;
  logic             c;
  logic             v;
  logic             busy;
  logic             done;

  modport master (output start, a, b, cin, opc,
                  input  w, z, n, c, v, busy, done);
  modport slave  (input  start, a, b, cin, opc,
                  output w, z, n, c, v, busy, done);
endinterface

// File: rtl/seq_alu_iter_unit.sv
// Iterative datapath for SHL (1 bit per step) and unsigned MUL (shift-add,
// multiplier LSB first). Exposes the post-step result so the final step can
// be captured straight into the result register.
module alu_iter_unit #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             is_mul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW:0]     cnt_init,
  input  logic             step,
  output logic             last,
  output logic [WIDTH-1:0] res,
  output logic             cout
);

  logic [SHW:0]         cnt;
  logic                 mul_mode;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc_next;

  assign last = (cnt == (SHW+1)'(1));

  // SHL reuses acc as the shift register; only its low half is meaningful
  always_comb begin
    acc_next = acc << 1;
    cout     = acc[WIDTH-1];
    if (mul_mode) begin
      acc_next = acc + (mplier[0] ? mcand : '0);
      cout     = |acc_next[2*WIDTH-1:WIDTH];
    end
    res = acc_next[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      mul_mode <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
    end else if (load) begin
      cnt      <= cnt_init;
      mul_mode <= is_mul;
      acc      <= is_mul ? '0 : {{WIDTH{1'b0}}, a};
      mcand    <= {{WIDTH{1'b0}}, a};
      mplier   <= b;
    end else if (step) begin
      cnt      <= cnt - (SHW+1)'(1);
      acc      <= acc_next;
      mcand    <= mcand << 1;
      mplier   <= mplier >> 1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU with start/busy/done handshake: single-cycle logic ops and
// ADD/SUB, iterative SHL and MUL, registered result and flags.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_alu_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state;
  opcode_e          op;
  logic [SHW-1:0]   shamt;
  logic             accept, multi, load_res, iter_fin;
  logic [SHW:0]     cnt_init;
  logic [WIDTH:0]   sum, dif;
  cv_t              cv;
  logic [WIDTH-1:0] r_w, iter_res;
  logic             r_c, r_v, iter_c, iter_last;
  logic [WIDTH-1:0] w_q;
  logic             z_q, n_q, c_q, v_q, done_q;

  assign op       = opcode_e'(bus.opc);
  assign shamt    = bus.b[SHW-1:0];
  assign accept   = bus.start && (state == S_IDLE);
  assign multi    = (op == OP_MUL) || ((op == OP_SHL) && (shamt != '0));
  assign iter_fin = (state == S_BUSY) && iter_last;
  assign load_res = (accept && !multi) || iter_fin;
  assign cnt_init = (op == OP_MUL) ? (SHW+1)'(WIDTH) : {1'b0, shamt};

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept && multi),
    .is_mul   (op == OP_MUL),
    .a        (bus.a),
    .b        (bus.b),
    .cnt_init (cnt_init),
    .step     (state == S_BUSY),
    .last     (iter_last),
    .res      (iter_res),
    .cout     (iter_c)
  );

  always_comb begin
    sum = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
    dif = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.cin};
    cv  = '0;
    r_w = '0;
    r_c = 1'b0;
    r_v = 1'b0;
    if (iter_fin) begin
      r_w = iter_res;
      r_c = iter_c;
    end else begin
      case (op)
        OP_ADD: begin
          cv  = addsub_cv(1'b0, bus.a[WIDTH-1], bus.b[WIDTH-1], sum[WIDTH-1], sum[WIDTH]);
          r_w = sum[WIDTH-1:0];
          r_c = cv.c;
          r_v = cv.v;
        end
        OP_SUB: begin
          cv  = addsub_cv(1'b1, bus.a[WIDTH-1], bus.b[WIDTH-1], dif[WIDTH-1], dif[WIDTH]);
          r_w = dif[WIDTH-1:0];
          r_c = cv.c;
          r_v = cv.v;
        end
        OP_AND:  r_w = bus.a & bus.b;
        OP_OR:   r_w = bus.a | bus.b;
        OP_XOR:  r_w = bus.a ^ bus.b;
        OP_NOT:  r_w = ~bus.a;
        OP_SHL:  r_w = bus.a;  // only reached with a zero shift amount
        default: r_w = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      w_q    <= '0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= load_res;
      if (load_res) begin
        w_q <= r_w;
        z_q <= (r_w == '0);
        n_q <= r_w[WIDTH-1];
        c_q <= r_c;
        v_q <= r_v;
      end
      case (state)
        S_IDLE:  if (accept && multi) state <= S_BUSY;
        S_BUSY:  if (iter_last) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.w    = w_q;
  assign bus.z    = z_q;
  assign bus.n    = n_q;
  assign bus.c    = c_q;
  assign bus.v    = v_q;
  assign bus.done = done_q;
  assign bus.busy = (state == S_BUSY);

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: stimulus pushes expected results with their
// due cycle, a negedge monitor pops and compares on every done.
module tb_seq_alu;

  typedef struct {
    logic [15:0] w;
    logic        c;
    logic        v;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  seq_alu_if #(.WIDTH(16)) bus();

  seq_alu #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: done=1 with no outstanding op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("w", {16'h0, bus.w}, {16'h0, e.w});
        chk("z", {31'h0, bus.z}, {31'h0, (e.w == 16'h0)});
        chk("n", {31'h0, bus.n}, {31'h0, e.w[15]});
        chk("c", {31'h0, bus.c}, {31'h0, e.c});
        chk("v", {31'h0, bus.v}, {31'h0, e.v});
        chk("done_cycle", cyc, e.lat);
      end
    end
  end

  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic cin);
    exp_t e;
    int   s, ss, k;
    longint unsigned p;
    e.w = 16'h0; e.c = 1'b0; e.v = 1'b0; e.lat = 1;
    case (op)
      3'd0: begin
        s  = int'(a) + int'(b) + int'(cin);
        ss = int'($signed(a)) + int'($signed(b)) + int'(cin);
        e.w = 16'(s); e.c = (s > 65535); e.v = (ss > 32767) || (ss < -32768);
      end
      3'd1: begin
        s  = int'(a) - int'(b) - int'(cin);
        ss = int'($signed(a)) - int'($signed(b)) - int'(cin);
        e.w = 16'(s); e.c = (s < 0); e.v = (ss > 32767) || (ss < -32768);
      end
      3'd2: e.w = a & b;
      3'd3: e.w = a | b;
      3'd4: e.w = a ^ b;
      3'd5: e.w = ~a;
      3'd6: begin
        k   = int'(b[3:0]);
        e.w = a << k;
        e.c = (k != 0) ? a[16-k] : 1'b0;
        e.lat = (k == 0) ? 1 : k + 1;
      end
      default: begin
        p   = longint'(a) * longint'(b);
        e.w = p[15:0];
        e.c = (p[31:16] != 16'h0);
        e.lat = 17;
      end
    endcase
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [15:0] ew, input logic ec,
                       input logic ev, input int lat);
    exp_t e;
    bus.opc = op; bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1;
    e.w = ew; e.c = ec; e.v = ev; e.lat = cyc + lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    bus.cin = 1'($urandom);
    @(negedge clk);
  endtask

  task automatic issue_model(input logic [2:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic cin);
    exp_t e;
    e = model(op, a, b, cin);
    issue(op, a, b, cin, e.w, e.c, e.v, e.lat);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 60 && bus.done !== 1'b1; i++) @(negedge clk);
    chk({name, "_done_seen"}, {31'h0, bus.done}, 32'h1);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.opc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_w", {16'h0, bus.w}, 32'h0);
    chk("rst_flags", {27'h0, bus.z, bus.n, bus.c, bus.v, bus.busy}, 32'h0);
    chk("rst_done", {31'h0, bus.done}, 32'h0);

    issue(3'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1);  wait_done("add_ovf");
    issue(3'd1, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0, 1);  wait_done("sub_zero");
    issue(3'd1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1);  wait_done("sub_borrow");
    issue(3'd0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1);  wait_done("add_cin");

    issue(3'd7, 16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b1, 1'b0, 17);
    chk("mul_busy", {31'h0, bus.busy}, 32'h1);
    wait_done("mul_hi");
    chk("mul_busy_low_at_done", {31'h0, bus.busy}, 32'h0);
    issue(3'd7, 16'h00FF, 16'h0003, 1'b0, 16'h02FD, 1'b0, 1'b0, 17); wait_done("mul_small");

    issue(3'd6, 16'h0001, 16'd15, 1'b0, 16'h8000, 1'b0, 1'b0, 16);
    repeat (3) begin
      bus.start = 1'b1; bus.opc = 3'd0; bus.a = 16'h1111; bus.b = 16'h2222;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
    end
    wait_done("shl15");
    issue(3'd6, 16'hFFFF, 16'd0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1);     wait_done("shl0");
    issue(3'd6, 16'hFFFF, 16'd1, 1'b0, 16'hFFFE, 1'b1, 1'b0, 2);     wait_done("shl1");

    // reset in cycle 5 of a MUL: result discarded, no done
    issue(3'd7, 16'h0003, 16'h0004, 1'b0, 16'h000C, 1'b0, 1'b0, 17);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_w", {16'h0, bus.w}, 32'h0);
    chk("abort_flags", {27'h0, bus.z, bus.n, bus.c, bus.v, bus.busy}, 32'h0);
    chk("abort_done", {31'h0, bus.done}, 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(3'd0, 16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0, 1);  wait_done("add_after_rst");

    // back-to-back: AND issued in the MUL's done cycle
    issue(3'd7, 16'h1234, 16'h0002, 1'b0, 16'h2468, 1'b0, 1'b0, 17);
    wait_done("mul_b2b");
    issue(3'd2, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 1'b0, 1'b0, 1);
    wait_done("and_b2b");
    issue(3'd3, 16'hF000, 16'h000F, 1'b0, 16'hF00F, 1'b0, 1'b0, 1);  wait_done("or");
    issue(3'd4, 16'hAAAA, 16'hFFFF, 1'b0, 16'h5555, 1'b0, 1'b0, 1);  wait_done("xor");
    issue(3'd5, 16'h00FF, 16'h1234, 1'b1, 16'hFF00, 1'b0, 1'b0, 1);  wait_done("not");

    for (int i = 0; i < 40; i++) begin
      issue_model(3'(i % 8), 16'($urandom), 16'($urandom), 1'($urandom));
      wait_done("sweep");
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
